// File: rtl/level_sequencer_pkg.sv
// Shared types for the symbol-counting game controller.
// Holds the FSM state encoding, datapath widths and the |a-b| helper.
package symcounter_pkg;

  localparam int DIFF_W  = 5;
  localparam int LEVEL_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHOW  = 3'd2,
    S_COUNT = 3'd3,
    S_JUDGE = 3'd4,
    S_LOSE  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  function automatic logic [DIFF_W-1:0] abs_diff(
    input logic [DIFF_W-1:0] a,
    input logic [DIFF_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Game-flow bundle between level_sequencer (master) and the game.
// Inputs: start, userDone, target, userCount; rest are outputs.
interface level_sequencer_if;
  import symcounter_pkg::*;

  logic               start;
  logic               userDone;
  logic [DIFF_W-1:0]  target;
  logic [DIFF_W-1:0]  userCount;
  logic               targetReq;
  logic               clearCount;
  logic               showEn;
  logic               countEn;
  logic               levelComplete;
  logic [DIFF_W-1:0]  difference;
  logic [LEVEL_W-1:0] level;
  logic [3:0]         ticksLeft;
  logic               lose;
  logic               win;
  logic [2:0]         state;

  modport master (
    input  start, userDone, target, userCount,
    output targetReq, clearCount, showEn, countEn,
    output levelComplete, difference, level,
    output ticksLeft, lose, win, state
  );

  modport slave (
    output start, userDone, target, userCount,
    input  targetReq, clearCount, showEn, countEn,
    input  levelComplete, difference, level,
    input  ticksLeft, lose, win, state
  );

endinterface

// File: rtl/level_sequencer_tick_divider.sv
// Game tick generator: one-cycle tick every TICK_DIV cycles.
// Ports: clk, rst_n (async low), clr (hold at 0), tick (pulse out).
module tick_divider #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Counter sits at 0 while cleared, so the first cycle
  // after clr drops is cycle 0 of a fresh tick period.
  assign tick = !clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: LOAD/SHOW/COUNT/JUDGE flow, |count-target| judge.
// Ports: Clk100M, Reset_n (async low), bus (level_sequencer_if.master).
module level_sequencer
  import symcounter_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int SHOW_TICKS  = 3,
  parameter int COUNT_TICKS = 10,
  parameter int TOLERANCE   = 2,
  parameter int MAX_LEVEL   = 15
) (
  input  logic               Clk100M,
  input  logic               Reset_n,
  level_sequencer_if.master  bus
);

  state_t             r_state;
  logic               r_load_ph;
  logic [3:0]         r_show_ticks;
  logic [3:0]         r_ticks_left;
  logic [DIFF_W-1:0]  r_tgt;
  logic [DIFF_W-1:0]  r_diff;
  logic [LEVEL_W-1:0] r_level;
  logic               r_target_req;
  logic               r_clear;
  logic               r_show;
  logic               r_count;
  logic               r_lvl_done;
  logic               r_lose;
  logic               r_win;

  logic w_tick;
  logic w_clr;
  logic w_exit;

  // Timebase only runs in the timed states and restarts on entry.
  assign w_clr = !((r_state == S_SHOW) || (r_state == S_COUNT));

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (Clk100M),
    .rst_n (Reset_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Early finish and final tick on the same cycle is one exit.
  assign w_exit = bus.userDone ||
                  (w_tick && (r_ticks_left == 4'd1));

  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_load_ph    <= 1'b0;
      r_show_ticks <= '0;
      r_ticks_left <= '0;
      r_tgt        <= '0;
      r_diff       <= '0;
      r_level      <= '0;
      r_target_req <= 1'b0;
      r_clear      <= 1'b0;
      r_show       <= 1'b0;
      r_count      <= 1'b0;
      r_lvl_done   <= 1'b0;
      r_lose       <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_target_req <= 1'b0;
      r_clear      <= 1'b0;
      r_lvl_done   <= 1'b0;
      unique case (r_state)
        S_IDLE, S_LOSE, S_WIN: begin
          if (bus.start) begin
            r_state      <= S_LOAD;
            r_load_ph    <= 1'b0;
            r_level      <= '0;
            r_diff       <= '0;
            r_lose       <= 1'b0;
            r_win        <= 1'b0;
            r_target_req <= 1'b1;
            r_clear      <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
          end else begin
            r_tgt        <= bus.target;
            r_state      <= S_SHOW;
            r_show       <= 1'b1;
            r_show_ticks <= '0;
          end
        end
        S_SHOW: begin
          if (w_tick) begin
            if (r_show_ticks == 4'(SHOW_TICKS - 1)) begin
              r_state      <= S_COUNT;
              r_show       <= 1'b0;
              r_count      <= 1'b1;
              r_ticks_left <= 4'(COUNT_TICKS);
            end else begin
              r_show_ticks <= r_show_ticks + 4'd1;
            end
          end
        end
        S_COUNT: begin
          if (w_exit) begin
            r_state      <= S_JUDGE;
            r_count      <= 1'b0;
            r_ticks_left <= '0;
            r_diff       <= abs_diff(bus.userCount, r_tgt);
            r_lvl_done   <= 1'b1;
          end else if (w_tick) begin
            r_ticks_left <= r_ticks_left - 4'd1;
          end
        end
        S_JUDGE: begin
          if (r_diff > DIFF_W'(TOLERANCE)) begin
            r_state <= S_LOSE;
            r_lose  <= 1'b1;
          end else if (r_level == LEVEL_W'(MAX_LEVEL)) begin
            r_state <= S_WIN;
            r_win   <= 1'b1;
          end else begin
            r_state      <= S_LOAD;
            r_load_ph    <= 1'b0;
            r_level      <= r_level + LEVEL_W'(1);
            r_target_req <= 1'b1;
            r_clear      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.targetReq     = r_target_req;
  assign bus.clearCount    = r_clear;
  assign bus.showEn        = r_show;
  assign bus.countEn       = r_count;
  assign bus.levelComplete = r_lvl_done;
  assign bus.difference    = r_diff;
  assign bus.level         = r_level;
  assign bus.ticksLeft     = r_ticks_left;
  assign bus.lose          = r_lose;
  assign bus.win           = r_win;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with TICK_DIV=4.
// Table of level vectors plus reset and win sequences.
module tb_level_sequencer;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_LOSE = 5;
  localparam int ST_WIN  = 6;

  logic Clk100M = 1'b0;
  logic Reset_n = 1'b0;

  level_sequencer_if bus ();

  level_sequencer #(
    .TICK_DIV    (4),
    .SHOW_TICKS  (2),
    .COUNT_TICKS (3),
    .TOLERANCE   (2),
    .MAX_LEVEL   (15)
  ) dut (
    .Clk100M (Clk100M),
    .Reset_n (Reset_n),
    .bus     (bus.master)
  );

  always #5 Clk100M = ~Clk100M;

  typedef struct {
    int start;
    int start_mid;
    int tgt;
    int uc;
    int done_at;
    int exp_show;
    int exp_cnt;
    int exp_diff;
    int exp_state;
    int exp_level;
    int exp_lose;
    int exp_win;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int show;
    int cnt;
    bit done;
    bus.target    = 5'(v.tgt);
    bus.userCount = 5'(v.uc);
    if (v.start != 0) begin
      bus.start = 1'b1;
      tick1();
      bus.start = 1'b0;
      chk("start_lose_clr", int'(bus.lose), 0);
      chk("start_win_clr", int'(bus.win), 0);
      chk("start_level0", int'(bus.level), 0);
    end
    chk("targetReq", int'(bus.targetReq), 1);
    chk("clearCount", int'(bus.clearCount), 1);
    show = 0;
    cnt  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick1();
      bus.userDone = 1'b0;
      bus.start    = 1'b0;
      if (bus.levelComplete) begin
        done = 1'b1;
      end else begin
        if (bus.showEn) begin
          if (show == 0 && v.start_mid != 0) bus.start = 1'b1;
          show++;
        end
        if (bus.countEn) begin
          if (cnt == 0) chk("ticksLeft_load", int'(bus.ticksLeft), 3);
          if (cnt == v.done_at) bus.userDone = 1'b1;
          cnt++;
        end
      end
    end
    bus.start = 1'b0;
    chk("levelComplete_seen", int'(done), 1);
    chk("show_cycles", show, v.exp_show);
    chk("count_cycles", cnt, v.exp_cnt);
    chk("difference", int'(bus.difference), v.exp_diff);
    chk("ticksLeft_judge", int'(bus.ticksLeft), 0);
    tick1();
    chk("levelComplete_once", int'(bus.levelComplete), 0);
    chk("state_after", int'(bus.state), v.exp_state);
    chk("level_after", int'(bus.level), v.exp_level);
    chk("lose_after", int'(bus.lose), v.exp_lose);
    chk("win_after", int'(bus.win), v.exp_win);
  endtask

  vec_t tbl[7];
  vec_t w;

  initial begin
    bus.start     = 1'b0;
    bus.userDone  = 1'b0;
    bus.target    = '0;
    bus.userCount = '0;

    tbl[0] = '{1, 0,  9, 10, -1, 8, 12,  1, ST_LOAD, 1, 0, 0};
    tbl[1] = '{0, 1,  7,  7,  1, 8,  2,  0, ST_LOAD, 2, 0, 0};
    tbl[2] = '{0, 0,  4,  9, -1, 8, 12,  5, ST_LOSE, 2, 1, 0};
    tbl[3] = '{1, 0, 20, 18, 11, 8, 12,  2, ST_LOAD, 1, 0, 0};
    tbl[4] = '{0, 0,  0, 31,  0, 8,  1, 31, ST_LOSE, 1, 1, 0};
    tbl[5] = '{1, 0, 31, 28, -1, 8, 12,  3, ST_LOSE, 0, 1, 0};
    tbl[6] = '{1, 0, 12, 10,  5, 8,  6,  2, ST_LOAD, 1, 0, 0};

    #2;
    chk("rst_outputs", int'({bus.targetReq, bus.clearCount,
        bus.showEn, bus.countEn, bus.levelComplete,
        bus.difference, bus.level, bus.ticksLeft,
        bus.lose, bus.win}), 0);
    chk("rst_state", int'(bus.state), ST_IDLE);
    #20;
    Reset_n = 1'b1;
    tick1();
    bus.userDone = 1'b1;
    tick1();
    bus.userDone = 1'b0;
    tick1();
    chk("idle_ignores_userDone", int'(bus.state), ST_IDLE);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    for (int lv = 1; lv <= 15; lv++) begin
      w = '{0, 0, 5, 7, 0, 8, 1, 2,
            (lv == 15) ? ST_WIN : ST_LOAD,
            (lv == 15) ? 15 : lv + 1, 0,
            (lv == 15) ? 1 : 0};
      run_vec(w);
    end
    repeat (3) tick1();
    chk("win_sticky", int'(bus.win), 1);
    chk("win_level_hold", int'(bus.level), 15);

    w = '{1, 0, 9, 10, -1, 8, 12, 1, ST_LOAD, 1, 0, 0};
    run_vec(w);

    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        tick1();
        if (bus.countEn) seen = 1'b1;
      end
      chk("reach_count", int'(seen), 1);
      tick1();
      #3;
      Reset_n = 1'b0;
      #1;
      chk("async_rst_outputs", int'({bus.targetReq,
          bus.clearCount, bus.showEn, bus.countEn,
          bus.levelComplete, bus.difference, bus.level,
          bus.ticksLeft, bus.lose, bus.win}), 0);
      chk("async_rst_state", int'(bus.state), ST_IDLE);
      tick1();
      Reset_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
        tick1();
        if (bus.levelComplete) seen = 1'b1;
      end
      chk("rst_no_levelComplete", int'(seen), 0);
      chk("rst_release_idle", int'(bus.state), ST_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
